// File: rtl/msp_trace_buf.sv
// Instruction trace buffer: closes one record per decode strobe into a circular buffer,
// with a PC-match trigger, a post-trigger record count and an oldest-first readout after freeze.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   IDLE      | after reset; decode only tracks the current record
//   ARMED     | capturing, watching for the trigger PC
//   TRIGGERED | capturing the post-trigger records
//   FROZEN    | capture stopped, records drained via rd_req
module msp_trace_buf #(
    parameter int DEPTH  = 16,
    parameter int CYC_W  = 8,
    parameter int POST_W = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int RW    = 33 + CYC_W
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic              start,
    input  logic              stop,
    input  logic              trig_en,
    input  logic [15:0]       trig_pc,
    input  logic [POST_W-1:0] post_cnt,
    input  logic              decode,
    input  logic [15:0]       ir,
    input  logic [15:0]       pc,
    input  logic              irq_detect,
    input  logic              rd_req,
    output logic [RW-1:0]     rd_data,
    output logic              rd_valid,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_TRIG   = 2'd2,
        S_FROZEN = 2'd3
    } state_t;

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    state_t            st;
    logic [RW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic [15:0]       cur_ir;
    logic [15:0]       cur_pc;
    logic              cur_irq;
    logic              cur_vld;
    logic [CYC_W-1:0]  cyc;
    logic [POST_W-1:0] remain;

    logic              capturing;
    logic              wr_en;
    logic              rd_en;
    logic              latch_en;
    logic              trig_hit;
    logic [RW-1:0]     wr_rec;

    assign capturing = (st == S_ARMED) || (st == S_TRIG);
    assign wr_en     = capturing && decode && cur_vld && !start;
    assign rd_en     = (st == S_FROZEN) && rd_req && (cnt != '0) && !start;
    // A start beats the freeze, so the coinciding decode still refreshes cur
    assign latch_en  = decode && ((st != S_FROZEN) || start);
    assign trig_hit  = trig_en && (cur_pc == trig_pc);
    assign wr_rec    = {cur_irq, cyc, cur_ir, cur_pc};

    always_ff @(posedge mclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_rec;
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            st       <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            cur_ir   <= '0;
            cur_pc   <= '0;
            cur_irq  <= 1'b0;
            cur_vld  <= 1'b0;
            cyc      <= '0;
            remain   <= '0;
        end else begin
            rd_valid <= 1'b0;

            if (latch_en) begin
                cur_ir  <= ir;
                cur_pc  <= pc;
                cur_irq <= irq_detect;
                cyc     <= CYC_W'(1);
                cur_vld <= 1'b1;
            end else if (cyc != '1) begin
                cyc <= cyc + 1'b1;
            end

            if (start) begin
                cur_vld  <= 1'b0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                cnt      <= '0;
                overflow <= 1'b0;
                st       <= S_ARMED;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (cnt != CNT_FULL) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        rd_ptr   <= rd_ptr + 1'b1;
                        overflow <= 1'b1;
                    end
                end

                if (rd_en) begin
                    rd_data  <= mem[rd_ptr];
                    rd_valid <= 1'b1;
                    rd_ptr   <= rd_ptr + 1'b1;
                    cnt      <= cnt - 1'b1;
                end

                case (st)
                    S_ARMED: begin
                        if (wr_en && trig_hit) begin
                            remain <= post_cnt;
                            st     <= (post_cnt == '0) ? S_FROZEN : S_TRIG;
                        end
                        if (stop) st <= S_FROZEN;
                    end
                    S_TRIG: begin
                        if (wr_en) begin
                            remain <= remain - 1'b1;
                            if (remain == POST_W'(1)) st <= S_FROZEN;
                        end
                        if (stop) st <= S_FROZEN;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign count = cnt;
    assign state = st;

endmodule

// File: tb/tb_msp_trace_buf.sv
// Self-checking bench for msp_trace_buf: a queue-based record model collects expected
// records as decodes are driven; reads pop and compare them in order.
module tb_msp_trace_buf;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic        start, stop, trig_en, decode, irq_detect, rd_req;
    logic [15:0] trig_pc, ir, pc;
    logic [7:0]  post_cnt;
    logic [40:0] rd_data;
    logic        rd_valid;
    logic [4:0]  count;
    logic        overflow;
    logic [1:0]  state;

    int n_chk  = 0;
    int n_pass = 0;

    msp_trace_buf dut (
        .mclk       (mclk),
        .puc_rst    (puc_rst),
        .start      (start),
        .stop       (stop),
        .trig_en    (trig_en),
        .trig_pc    (trig_pc),
        .post_cnt   (post_cnt),
        .decode     (decode),
        .ir         (ir),
        .pc         (pc),
        .irq_detect (irq_detect),
        .rd_req     (rd_req),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .count      (count),
        .overflow   (overflow),
        .state      (state)
    );

    always #5 mclk = ~mclk;

    // Reference model: records as a queue, oldest at the front
    logic [40:0] exp_q[$];
    int          m_state;
    int          m_cyc;
    int          m_remain;
    logic        m_cvld, m_ovf, m_irq;
    logic [15:0] m_ir, m_pc;

    always @(posedge mclk or posedge puc_rst) begin
        int prev;
        if (puc_rst) begin
            exp_q.delete();
            m_state = 0; m_cyc = 0; m_remain = 0;
            m_cvld = 0; m_ovf = 0; m_irq = 0; m_ir = 0; m_pc = 0;
        end else begin
            prev = m_state;
            if (decode && (prev != 3 || start)) begin
                if (!start && (prev == 1 || prev == 2) && m_cvld) begin
                    exp_q.push_back({m_irq, 8'(m_cyc), m_ir, m_pc});
                    if (exp_q.size() > 16) begin
                        void'(exp_q.pop_front());
                        m_ovf = 1;
                    end
                    if (prev == 1 && trig_en && m_pc == trig_pc) begin
                        m_remain = int'(post_cnt);
                        m_state  = (post_cnt == 0) ? 3 : 2;
                    end else if (prev == 2) begin
                        m_remain--;
                        if (m_remain == 0) m_state = 3;
                    end
                end
                m_ir = ir; m_pc = pc; m_irq = irq_detect; m_cyc = 1; m_cvld = 1;
            end else begin
                m_cyc = (m_cyc < 255) ? m_cyc + 1 : 255;
            end
            if (start) begin
                exp_q.delete();
                m_cvld = 0; m_ovf = 0; m_state = 1;
            end else if (stop && (prev == 1 || prev == 2)) begin
                m_state = 3;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    task automatic pulse_stop();
        stop = 1; tick(); stop = 0;
    endtask

    task automatic dec(input logic [15:0] p, input logic i, input int gap);
        decode = 1; pc = p; ir = 16'($urandom); irq_detect = i;
        tick();
        decode = 0; pc = '0; ir = '0; irq_detect = 0;
        repeat (gap - 1) tick();
    endtask

    task automatic check_status(input string tag);
        check({tag, "_state"}, state, m_state);
        check({tag, "_count"}, count, exp_q.size());
        check({tag, "_ovf"}, overflow, m_ovf);
    endtask

    task automatic rd_one(input string tag, output logic [40:0] got);
        bit has;
        logic [40:0] e;
        has = (m_state == 3) && (exp_q.size() > 0);
        rd_req = 1; tick(); rd_req = 0;
        got = rd_data;
        if (has) begin
            e = exp_q.pop_front();
            check({tag, "_vld"}, rd_valid, 1);
            check({tag, "_data"}, rd_data, e);
            check({tag, "_cnt"}, count, exp_q.size());
        end else begin
            check({tag, "_novld"}, rd_valid, 0);
        end
    endtask

    task automatic do_reset(input string tag);
        puc_rst = 1;
        #3;
        check({tag, "_state"}, state, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_rdv"}, rd_valid, 0);
        check({tag, "_ovf"}, overflow, 0);
        puc_rst = 0;
        tick();
    endtask

    initial begin
        logic [40:0] r;
        int gaps[5] = '{3, 1, 4, 2, 1};
        int nrd;

        puc_rst = 1; start = 0; stop = 0; trig_en = 0; trig_pc = '0; post_cnt = '0;
        decode = 0; ir = '0; pc = '0; irq_detect = 0; rd_req = 0;
        repeat (2) @(posedge mclk);
        #1;
        check("rst_state", state, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_rdv", rd_valid, 0);
        check("rst_rdata", rd_data, 0);
        puc_rst = 0;
        tick();

        // 1: spaced decodes, cycle counts, drain, read on empty
        pulse_start();
        check("t1_armed", state, 1);
        for (int i = 0; i < 5; i++) dec(16'hF000 + 16'(2 * i), i[0], gaps[i]);
        pulse_stop();
        check_status("t1");
        check("t1_count4", count, 4);
        for (int i = 0; i < 4; i++) begin
            rd_one("t1_rd", r);
            check("t1_cycles", r[39:32], gaps[i]);
            check("t1_pc", r[15:0], 16'hF000 + 16'(2 * i));
        end
        check("t1_count0", count, 0);
        rd_one("t1_empty", r);

        // 2: overflow keeps the newest 16 records
        pulse_start();
        for (int i = 0; i < 21; i++) dec(16'h1000 + 16'(2 * i), (i % 3) == 0, 1);
        pulse_stop();
        check_status("t2");
        check("t2_count16", count, 16);
        check("t2_ovf1", overflow, 1);
        rd_one("t2_rd", r);
        check("t2_oldest_pc", r[15:0], 16'h1008);
        for (int i = 0; i < 15; i++) rd_one("t2_rd", r);
        rd_one("t2_empty", r);

        // 3: trigger with two post-trigger records
        trig_en = 1; trig_pc = 16'hF010; post_cnt = 8'd2;
        pulse_start();
        for (int i = 0; i < 15; i++) begin
            dec(16'hF000 + 16'(2 * i), 0, 2);
            if (i == 9) check("t3_trig_state", state, 2);
        end
        check_status("t3");
        check("t3_frozen", state, 3);
        check("t3_count11", count, 11);
        nrd = exp_q.size();
        for (int i = 0; i < nrd; i++) begin
            rd_one("t3_rd", r);
            if (i == nrd - 3) check("t3_trig_rec", r[15:0], 16'hF010);
            if (i == nrd - 1) check("t3_last_pc", r[15:0], 16'hF014);
        end

        // 4: post_cnt = 0 freezes on the trigger write
        trig_pc = 16'h2006; post_cnt = 8'd0;
        pulse_start();
        for (int i = 0; i < 8; i++) dec(16'h2000 + 16'(2 * i), i == 2, 1);
        check_status("t4");
        check("t4_count4", count, 4);
        for (int i = 0; i < 4; i++) rd_one("t4_rd", r);
        check("t4_last_pc", r[15:0], 16'h2006);
        trig_en = 0;

        // 5: long gap saturates the cycle count
        pulse_start();
        dec(16'h4000, 0, 300);
        dec(16'h4002, 1, 1);
        dec(16'h4004, 0, 1);
        pulse_stop();
        check_status("t5");
        rd_one("t5_rd", r);
        check("t5_sat", r[39:32], 255);
        rd_one("t5_rd", r);
        check("t5_cyc1", r[39:32], 1);

        // 6: reset in TRIGGERED and during readout, then start with stop
        trig_en = 1; trig_pc = 16'h3002; post_cnt = 8'd5;
        pulse_start();
        for (int i = 0; i < 4; i++) dec(16'h3000 + 16'(2 * i), 0, 1);
        check("t6_trig", state, 2);
        do_reset("t6_rst_trig");
        trig_en = 0;
        pulse_start();
        for (int i = 0; i < 5; i++) dec(16'h5000 + 16'(2 * i), 0, 1);
        pulse_stop();
        rd_one("t6_rd", r);
        do_reset("t6_rst_rd");
        start = 1; stop = 1; tick(); start = 0; stop = 0;
        check("t6_ss_state", state, 1);
        check("t6_ss_count", count, 0);
        dec(16'h6000, 0, 1);
        dec(16'h6002, 0, 1);
        check_status("t6_after");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
